// File: rtl/ecc_mod_inverse_pkg.sv
// Shared definitions for the ECC modular-arithmetic blocks: FSM encoding,
// default operand width and small constant/arithmetic helpers.
package ecc_mod_inverse_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam int DEFAULT_INTEGER_SIZE = 64;

  // Widest operand the shared helpers handle; callers zero-extend into it.
  localparam int MAX_W = 256;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int t = value - 1; t > 0; t = t >> 1) r++;
    return r;
  endfunction

  // a/2 mod p for odd p and a < p; a+p needs one extra bit before the shift.
  function automatic logic [MAX_W:0] half_mod(input logic [MAX_W:0] a,
                                              input logic [MAX_W:0] p);
    logic [MAX_W:0] s;
    s = a[0] ? (a + p) : a;
    return s >> 1;
  endfunction

endpackage

// File: rtl/ecc_mod_sub.sv
// Combinational (a - b) mod p for a, b already reduced below p.
module ecc_mod_sub
  import ecc_mod_inverse_pkg::*;
#(
  parameter int W = DEFAULT_INTEGER_SIZE
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] p,
  output logic [W-1:0] y
);

  logic [W-1:0] diff;

  // On borrow the wrapped difference plus p lands back in [0, p) modulo 2^W.
  assign diff = a - b;
  assign y    = (a >= b) ? diff : diff + p;

endmodule

// File: rtl/ecc_mod_inverse.sv
// Sequential modular inverter using the binary extended Euclidean algorithm;
// one shift or subtract step per clock, operands latched on go.
module ecc_mod_inverse
  import ecc_mod_inverse_pkg::*;
#(
  parameter int integer_size = DEFAULT_INTEGER_SIZE,
  parameter int MAX_CYCLES   = 4 * integer_size + 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    go,
  input  logic [integer_size-1:0] x,
  input  logic [integer_size-1:0] prime,
  output logic                    busy,
  output logic                    done,
  output logic [integer_size-1:0] x_inv,
  output logic                    err
);

  localparam int W  = integer_size;
  localparam int CW = clog2(MAX_CYCLES) + 1;
  localparam logic [W-1:0] ONE = W'(1);

  state_t         state_reg, state_next;
  logic [W-1:0]   u, v, p_r;
  logic [W:0]     x1, x2;
  logic [CW-1:0]  cyc;

  logic           bad_input;
  logic           u_one, v_one, timeout;
  logic [W:0]     half_x1, half_x2;
  logic [W-1:0]   sub_a [2];
  logic [W-1:0]   sub_b [2];
  logic [W-1:0]   sub_y [2];

  assign bad_input = (x == '0) || (x >= prime) || !prime[0];
  assign u_one     = (u == ONE);
  assign v_one     = (v == ONE);
  assign timeout   = (cyc == CW'(MAX_CYCLES));

  assign half_x1 = (W+1)'(half_mod((MAX_W+1)'(x1), (MAX_W+1)'(p_r)));
  assign half_x2 = (W+1)'(half_mod((MAX_W+1)'(x2), (MAX_W+1)'(p_r)));

  // Index 0 forms x1 - x2, index 1 forms x2 - x1 (both mod p_r).
  assign sub_a[0] = x1[W-1:0];
  assign sub_b[0] = x2[W-1:0];
  assign sub_a[1] = x2[W-1:0];
  assign sub_b[1] = x1[W-1:0];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sub
      ecc_mod_sub #(.W(W)) u_sub (
        .a (sub_a[gi]),
        .b (sub_b[gi]),
        .p (p_r),
        .y (sub_y[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (go) state_next = bad_input ? FIN : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (u_one || v_one || timeout) state_next = FIN;
      end
      FIN: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      u     <= '0;
      v     <= '0;
      p_r   <= '0;
      x1    <= '0;
      x2    <= '0;
      cyc   <= '0;
      x_inv <= '0;
      err   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (go) begin
            u   <= x;
            v   <= prime;
            p_r <= prime;
            x1  <= (W+1)'(1);
            x2  <= '0;
            cyc <= '0;
            // A rejected operand skips RUN, so the result is fixed here.
            if (bad_input) begin
              x_inv <= '0;
              err   <= 1'b1;
            end
          end
        end
        RUN: begin
          if (u_one || v_one) begin
            x_inv <= u_one ? x1[W-1:0] : x2[W-1:0];
            err   <= 1'b0;
          end else if (timeout) begin
            x_inv <= '0;
            err   <= 1'b1;
          end else begin
            cyc <= cyc + CW'(1);
            if (!u[0]) begin
              u  <= u >> 1;
              x1 <= half_x1;
            end else if (!v[0]) begin
              v  <= v >> 1;
              x2 <= half_x2;
            end else if (u >= v) begin
              u  <= u - v;
              x1 <= {1'b0, sub_y[0]};
            end else begin
              v  <= v - u;
              x2 <= {1'b0, sub_y[1]};
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ecc_mod_inverse.sv
// Scoreboard bench for ecc_mod_inverse: expectations from a division-based
// extended Euclid model are queued at issue and compared on each done pulse.
module tb_ecc_mod_inverse;

  localparam int W    = 64;
  localparam int MAXC = 4 * W + 4;
  localparam logic [W-1:0] P61 = 64'h1FFF_FFFF_FFFF_FFFF;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         go  = 1'b0;
  logic [W-1:0] x   = '0;
  logic [W-1:0] prime = '0;
  logic         busy, done, err;
  logic [W-1:0] x_inv;

  typedef struct {
    logic [W-1:0] inv;
    logic         e;
    logic [W-1:0] p;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ecc_mod_inverse #(.integer_size(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .go    (go),
    .x     (x),
    .prime (prime),
    .busy  (busy),
    .done  (done),
    .x_inv (x_inv),
    .err   (err)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Reference: textbook extended Euclid with quotients, coefficients kept mod p.
  function automatic void model_inv(input logic [W-1:0] xv, input logic [W-1:0] pv,
                                    output logic [W-1:0] inv, output logic e);
    logic [127:0] r0, r1, t0, t1, q, tmp, pp;
    inv = '0;
    e   = 1'b1;
    if (xv == '0 || xv >= pv || !pv[0]) return;
    pp = {64'b0, pv};
    r0 = pp;
    r1 = {64'b0, xv};
    t0 = '0;
    t1 = 128'd1;
    while (r1 != '0) begin
      q   = r0 / r1;
      tmp = r0 - q * r1;
      r0  = r1;
      r1  = tmp;
      tmp = (t0 + pp - (q * t1) % pp) % pp;
      t0  = t1;
      t1  = tmp;
    end
    if (r0 == 128'd1) begin
      inv = t0[W-1:0];
      e   = 1'b0;
    end
  endfunction

  always @(negedge clk) begin
    if (rst && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 x_inv=%0h required no pending operation", x_inv);
      end else begin
        cur = exp_q.pop_front();
        $display("op done: prime=%0h x_inv=%0h err=%0b (expected %0h/%0b)",
                 cur.p, x_inv, err, cur.inv, cur.e);
        check("x_inv", x_inv, cur.inv);
        check("err", W'(err), W'(cur.e));
        check("busy_at_done", W'(busy), '0);
        check("x_inv_below_prime", W'(x_inv < cur.p), W'(1));
      end
    end
  end

  // mode 0: plain op; 1: extra go (x=7) on 3rd busy cycle; 2: reset mid-RUN.
  task automatic run_op(input logic [W-1:0] xv, input logic [W-1:0] pv,
                        input logic [W-1:0] e_inv, input logic e_err,
                        input int exp_lat, input int mode);
    int   n;
    logic saw_idle;
    @(posedge clk); #1;
    x = xv; prime = pv; go = 1'b1;
    exp_q.push_back('{e_inv, e_err, pv});
    @(posedge clk); #1;
    go = 1'b0;
    x = {$urandom, $urandom};
    prime = {$urandom, $urandom};
    n = 0;
    saw_idle = 1'b0;
    forever begin
      @(negedge clk);
      n++;
      if (done) break;
      if (!busy) saw_idle = 1'b1;
      if (mode == 1 && n == 3) begin go = 1'b1; x = 7; prime = 23; end
      if (mode == 1 && n == 4) go = 1'b0;
      if (mode == 2 && n == 3) rst = 1'b0;
      if (mode == 2 && n == 4) begin
        check("abort_busy", W'(busy), '0);
        check("abort_done", W'(done), '0);
        check("abort_x_inv", x_inv, '0);
        check("abort_err", W'(err), '0);
        rst = 1'b1;
        void'(exp_q.pop_back());
        repeat (12) @(negedge clk);
        return;
      end
      if (n > MAXC + 4) begin
        checks++;
        errors++;
        $display("FAIL done_timeout: got no done after %0d cycles required at most %0d", n, MAXC + 2);
        void'(exp_q.pop_back());
        return;
      end
    end
    if (!e_err || exp_lat == 0) check("busy_until_done", W'(saw_idle), '0);
    if (exp_lat > 0) check("latency", W'(n), W'(exp_lat));
  endtask

  initial begin
    logic [W-1:0] xv, pv, inv;
    logic         e;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", W'(busy), '0);
    check("reset_done", W'(done), '0);
    check("reset_x_inv", x_inv, '0);
    check("reset_err", W'(err), '0);
    @(posedge clk); #1;
    rst = 1'b1;

    run_op(5, 23, 14, 1'b0, 0, 0);
    run_op(1, 97, 1, 1'b0, 2, 0);
    run_op(2, P61, 64'h1000_0000_0000_0000, 1'b0, 0, 0);
    run_op(P61 - 1, P61, P61 - 1, 1'b0, 0, 0);
    run_op(0, 23, 0, 1'b1, 1, 0);
    run_op(23, 23, 0, 1'b1, 1, 0);
    run_op(5, 24, 0, 1'b1, 1, 0);
    run_op(5, 23, 14, 1'b0, 0, 1);
    run_op(7, 23, 10, 1'b0, 0, 0);
    run_op(5, 23, 0, 1'b0, 0, 2);
    run_op(5, 23, 14, 1'b0, 0, 0);

    for (int i = 0; i < 30; i++) begin
      if (i % 3 == 0) pv = W'($urandom_range(1001, 3)) | W'(1);
      else            pv = {$urandom, $urandom} | W'(1);
      if (pv < 3) pv = 3;
      xv = {$urandom, $urandom} % pv;
      if (xv == '0) xv = 1;
      model_inv(xv, pv, inv, e);
      run_op(xv, pv, inv, e, 0, 0);
    end

    repeat (5) @(posedge clk);
    check("queue_empty", W'(exp_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: got simulation still running required finish");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/ecc_mod_inverse.md
Name: ecc_mod_inverse

Overview:
- Sequential modular inverter. Computes x_inv = x^-1 mod prime using the binary extended Euclidean algorithm (shift/subtract only, no divider).
- Sits directly upstream of the point-add stage. It takes the reduced difference (Qx - Px) mod p and supplies the inverse used to form lambda and nu.
- go/done handshake. Operands are latched on go, so the downstream adder can hold its own registered copies stable.

Parameters:
- integer_size, 64, operand width W in bits (prime, x, x_inv).
- MAX_CYCLES, 4*integer_size+4, watchdog limit on iteration cycles before err is forced.

Ports:
- clk  input  1  single clock; all logic updates on rising edge.
- rst  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
- go  input  1  start request; sampled only in IDLE.
- x  input  W  value to invert; unsigned, must satisfy 0 < x < prime.
- prime  input  W  odd modulus, > 2.
- busy  output  1  high from the cycle after go is accepted until done.
- done  output  1  one-cycle pulse; x_inv and err are valid from this cycle.
- x_inv  output  W  result; held until the next accepted go.
- err  output  1  1 = no inverse produced; x_inv = 0.

Behaviour:
- Reset (rst=0 at an edge): state=IDLE; busy=0, done=0, err=0, x_inv=0. Reset mid-operation aborts with no done pulse.
- Internal registers:
  - u, v: W bits.
  - x1, x2: W+1 bits, to hold x1+p before the shift.
  - p_r: W bits.
  - cyc: counter of clog2(MAX_CYCLES)+1 bits.
- States: IDLE, RUN, FIN.
- IDLE:
  - done=0.
  - On go=1: latch u=x, v=prime, x1=1, x2=0, p_r=prime, cyc=0, then go to RUN.
  - Input check in the same cycle: if x==0, x>=prime, or prime[0]==0, go to FIN with error flag set.
- RUN: exactly one action per cycle, in this priority order:
  1. If u==1 or v==1, go to FIN.
  2. Else if u even: u=u>>1; x1 = x1 even ? x1>>1 : (x1+p_r)>>1.
  3. Else if v even: same update on v, x2.
  4. Else if u>=v: u=u-v; x1 = x1>=x2 ? x1-x2 : x1+p_r-x2.
  5. Else: v=v-u; x2 = x2>=x1 ? x2-x1 : x2+p_r-x1.
  - cyc increments each RUN cycle. If cyc reaches MAX_CYCLES, go to FIN with error.
- FIN (one cycle), then IDLE:
  - done=1, busy=0.
  - x_inv = error ? 0 : (u==1 ? x1[W-1:0] : x2[W-1:0]); err = error.
- busy=1 while in RUN.
- Invariants: x1,x2 stay in [0,p_r) after every update; the result is always < prime.
- Latency: go accepted at edge N; done is high in the cycle after edge N+k+1, where k = number of RUN action cycles. k=0 for x=1, so the minimum latency is 2 cycles. Upper bound is MAX_CYCLES+2.
- go while busy or in FIN is ignored; there is no queueing. Changes to x/prime after acceptance have no effect.
- go held high continuously: a new operation starts in the IDLE cycle after each FIN.

Decomposition:
- Shared ecc package:
  - state encoding (IDLE/RUN/FIN)
  - default integer_size
  - function clog2
  - helper function half_mod(a,p): a even ? a>>1 : (a+p)>>1
- Natural sub-module: ecc_mod_sub. Combinational (a-b) mod p with a,b<p, reused by the point-add and point-double stages.

Test Plan:
- prime=23, x=5, go pulse -> done within MAX_CYCLES+2; x_inv=14, err=0; busy high until done.
- prime=97, x=1 -> done exactly 2 cycles after go accepted; x_inv=1.
- prime=2^61-1, x=2, W=64 -> x_inv=2^60, err=0. Also x=p-1 -> x_inv=p-1.
- Bad inputs, each independently -> one done pulse with err=1, x_inv=0:
  - prime=23, x=0
  - prime=23, x=23
  - prime=24, x=5
- prime=23, x=5, with a second go (x=7) at the 3rd busy cycle -> result is still 14. Afterwards a fresh go with x=7 -> 10.
- rst=0 asserted mid-RUN for one cycle -> outputs 0 next cycle, no done pulse. A following go with x=5, prime=23 -> 14.
